// File: rtl/flitzip_pkg.sv
// Shared types and default geometry for the flit compression controller.
package flitzip_pkg;

  localparam int unsigned DEF_INPUT_WIDTH = 128;
  localparam int unsigned DEF_CHUNK_SIZE  = 8;
  localparam int unsigned DEF_EN_BITS     = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    ENCODE = 2'd2,
    OUT    = 2'd3
  } state_t;

  function automatic int unsigned num_chunks(input int unsigned width,
                                             input int unsigned chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/prio_encoder_8_3.sv
// 8-to-3 priority encoder: index of the highest set bit, 0 when no bit is set.
module prio_encoder_8_3 (
  input  logic [7:0] din,
  output logic [2:0] dout
);

  always_comb begin
    dout = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (din[i]) dout = 3'(i);
    end
  end

endmodule

// File: rtl/flit_compress_ctrl.sv
// Base/delta compression controller: scans a flit chunk by chunk, emits base and delta width.
// Optional flit_count statistics port enabled by defining COMPRESS_STATS_EN.
module flit_compress_ctrl
  import flitzip_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH = DEF_INPUT_WIDTH,
  parameter int unsigned CHUNK_SIZE  = DEF_CHUNK_SIZE,
  parameter int unsigned EN_BITS     = DEF_EN_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INPUT_WIDTH-1:0] data_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INPUT_WIDTH-1:0] data_out,
  output logic [CHUNK_SIZE-1:0]  base_out,
  output logic [EN_BITS-1:0]     en_out
`ifdef COMPRESS_STATS_EN
  ,
  output logic [15:0]            flit_count
`endif
);

  localparam int unsigned NUM_CHUNKS = num_chunks(INPUT_WIDTH, CHUNK_SIZE);
  localparam int unsigned IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  state_t                 r_state, w_state_nxt;
  logic [INPUT_WIDTH-1:0] r_flit;
  logic [IDX_W-1:0]       r_idx;
  logic [CHUNK_SIZE-1:0]  r_max, r_min, r_base;
  logic [EN_BITS-1:0]     r_en;

  logic [CHUNK_SIZE-1:0]  w_chunk;
  logic [CHUNK_SIZE:0]    w_sum;
  logic [CHUNK_SIZE-1:0]  w_base;
  logic [CHUNK_SIZE-1:0]  w_delta;
  logic [7:0]             w_pe_in;
  logic [2:0]             w_pe_out;

  assign w_chunk = r_flit[r_idx*CHUNK_SIZE +: CHUNK_SIZE];
  // One extra sum bit so max+min never overflows before halving.
  assign w_sum   = {1'b0, r_max} + {1'b0, r_min};
  assign w_base  = CHUNK_SIZE'(w_sum >> 1);
  assign w_delta = r_max - w_base;

  always_comb begin
    w_pe_in = '0;
    for (int unsigned b = 0; b < 8 && b < CHUNK_SIZE; b++) begin
      w_pe_in[b] = w_delta[b];
    end
  end

  prio_encoder_8_3 u_prio (
    .din  (w_pe_in),
    .dout (w_pe_out)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)         w_state_nxt = SCAN;
      SCAN:    if (r_idx == LAST_IDX) w_state_nxt = ENCODE;
      ENCODE:                        w_state_nxt = OUT;
      OUT:     if (out_ready)        w_state_nxt = IDLE;
      default:                       w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flit <= '0;
      r_idx  <= '0;
      r_max  <= '0;
      r_min  <= '0;
      r_base <= '0;
      r_en   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_flit <= data_in;
            r_idx  <= '0;
          end
        end
        SCAN: begin
          if (r_idx == '0) begin
            r_max <= w_chunk;
            r_min <= w_chunk;
          end else begin
            if (w_chunk > r_max) r_max <= w_chunk;
            if (w_chunk < r_min) r_min <= w_chunk;
          end
          if (r_idx != LAST_IDX) r_idx <= r_idx + 1'b1;
        end
        ENCODE: begin
          r_base <= w_base;
          r_en   <= EN_BITS'(w_pe_out);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == OUT);
  assign data_out  = r_flit;
  assign base_out  = r_base;
  assign en_out    = r_en;

`ifdef COMPRESS_STATS_EN
  logic [15:0] r_flit_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flit_count <= '0;
    end else if (r_state == OUT && out_ready && r_flit_count != 16'hFFFF) begin
      r_flit_count <= r_flit_count + 16'd1;
    end
  end

  assign flit_count = r_flit_count;
`endif

endmodule

// File: tb/tb_flit_compress_ctrl.sv
// Directed scoreboard bench for flit_compress_ctrl (stats checks built when COMPRESS_STATS_EN is defined).
module tb_flit_compress_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;
  logic [7:0]   base_out;
  logic [2:0]   en_out;
`ifdef COMPRESS_STATS_EN
  logic [15:0]  flit_count;
`endif

  flit_compress_ctrl #(
    .INPUT_WIDTH (128),
    .CHUNK_SIZE  (8),
    .EN_BITS     (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_in    (data_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .base_out   (base_out),
    .en_out     (en_out)
`ifdef COMPRESS_STATS_EN
    ,
    .flit_count (flit_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] d;
    logic [7:0]   base;
    logic [2:0]   en;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned total  = 0;
  int unsigned passes = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic exp_t model(input logic [127:0] d);
    exp_t        e;
    logic [7:0]  c, mx, mn, delta;
    logic [8:0]  s;
    mx = 8'h00;
    mn = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      c = d[i*8 +: 8];
      if (c > mx) mx = c;
      if (c < mn) mn = c;
    end
    s      = {1'b0, mx} + {1'b0, mn};
    e.d    = d;
    e.base = s[8:1];
    delta  = mx - e.base;
    e.en   = 3'd0;
    for (int b = 7; b >= 0; b--) begin
      if (delta[b] && e.en == 3'd0) e.en = 3'(b);
    end
    e.d = d;
    return e;
  endfunction

  function automatic logic [127:0] garbage();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Waits for in_ready, presents one flit, pushes its expected result; returns just after the accept edge.
  task automatic accept(input logic [127:0] d);
    int unsigned k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("accept_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    data_in  = d;
    exp_q.push_back(model(d));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    data_in  = garbage();
  endtask

  // Counts edges from the accept edge until out_valid, scribbling data_in meanwhile.
  task automatic wait_out(output int unsigned lat);
    @(negedge clk);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      data_in = garbage();
    end
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 1'b1, 1'b0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, out_valid, 1'b1);
      chk({tag, "_data"},  data_out,  e.d);
      chk({tag, "_base"},  base_out,  e.base);
      chk({tag, "_en"},    en_out,    e.en);
    end
  endtask

  task automatic run_flit(input string tag, input logic [127:0] d);
    int unsigned lat;
    accept(d);
    wait_out(lat);
    chk({tag, "_latency"}, lat, 17);
    check_out(tag);
    @(negedge clk);
    chk({tag, "_idle_ready"}, in_ready, 1'b1);
    chk({tag, "_idle_valid"}, out_valid, 1'b0);
  endtask

  initial begin : stim
    logic [127:0] d;
    logic [127:0] held_d;
    logic [7:0]   held_b;
    logic [2:0]   held_e;
    int unsigned  lat;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    data_in   = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",  in_ready,  1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_data_out",  data_out,  '0);
    chk("rst_base_out",  base_out,  '0);
    chk("rst_en_out",    en_out,    '0);

    run_flit("all55", {16{8'h55}});
    chk("all55_base_const", base_out, 8'h55);

    d = {16{8'h40}};
    d[7:0]     = 8'h00;
    d[127:120] = 8'hFF;
    run_flit("extremes", d);

    for (int i = 0; i < 16; i++) d[i*8 +: 8] = 8'(8'h10 + i);
    run_flit("ramp", d);

    for (int n = 0; n < 3; n++) run_flit("random", garbage());

    // Backpressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    accept(garbage());
    wait_out(lat);
    chk("bp_latency", lat, 17);
    held_d = data_out;
    held_b = base_out;
    held_e = en_out;
    check_out("bp");
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("bp_hold_valid", out_valid, 1'b1);
      chk("bp_hold_ready", in_ready,  1'b0);
      chk("bp_hold_data",  data_out,  held_d);
      chk("bp_hold_base",  base_out,  held_b);
      chk("bp_hold_en",    en_out,    held_e);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", in_ready,  1'b1);
    chk("bp_release_valid", out_valid, 1'b0);

    // Reset while scanning chunk index 7.
    accept(garbage());
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(exp_q.pop_front());
    chk("scanrst_valid", out_valid, 1'b0);
    chk("scanrst_ready", in_ready,  1'b1);
    run_flit("after_scanrst", {16{8'h55}});

    // Reset in OUT coincident with out_ready: flit discarded, no handshake.
`ifdef COMPRESS_STATS_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif
    out_ready = 1'b0;
    accept(garbage());
    wait_out(lat);
    chk("outrst_latency", lat, 17);
    void'(exp_q.pop_front());
    out_ready = 1'b1;
    rst       = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("outrst_valid", out_valid, 1'b0);
    chk("outrst_ready", in_ready,  1'b1);
    chk("outrst_base",  base_out,  '0);
`ifdef COMPRESS_STATS_EN
    chk("outrst_count", flit_count, 16'd0);
    for (int n = 0; n < 3; n++) begin
      accept(garbage());
      wait_out(lat);
      check_out("stats");
    end
    @(negedge clk);
    chk("stats_count3", flit_count, 16'd3);
    force dut.r_flit_count = 16'hFFFF;
    @(negedge clk);
    release dut.r_flit_count;
    run_flit("stats_sat", garbage());
    chk("stats_saturate", flit_count, 16'hFFFF);
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
